// File: rtl/mshr_timer_sched.sv
// Purpose: gates per-MSHR expiry timers behind DDR calibration plus a settle window, then arbitrates expiries round-robin.
// Latency: calib_done -> SETTLE in 3 cycles, RUN SETTLE_CYCLES later; alloc in RUN -> expired flag TIMEOUT cycles later.
// Backpressure: expire_id is held stable while expire_valid is high and expire_ready is low; expired MSHRs wait their turn.
module mshr_timer_sched #(
  parameter int N_MSHR        = 5,
  parameter int ID_W          = (N_MSHR > 1) ? $clog2(N_MSHR) : 1,
  parameter int TIMER_W       = 16,
  parameter int TIMEOUT       = 1000,
  parameter int SETTLE_CYCLES = 10000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              calib_done,
  input  logic [N_MSHR-1:0] mshr_alloc,
  input  logic [N_MSHR-1:0] mshr_free,
  output logic              expire_valid,
  output logic [ID_W-1:0]   expire_id,
  input  logic              expire_ready,
  output logic              timers_enabled,
  output logic [1:0]        phase,
  output logic [N_MSHR-1:0] expired_vec
);

  typedef enum logic [1:0] {
    WAIT_CALIB = 2'd0,
    SETTLE     = 2'd1,
    RUN        = 2'd2
  } phase_t;

  // The settle counter only has to reach SETTLE_CYCLES-1.
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_EXP   = TIMER_W'(TIMEOUT);
  localparam logic [ID_W-1:0]    ID_LAST     = ID_W'(N_MSHR - 1);

  phase_t             state_q, state_d;
  logic               calib_s1, calib_s2;
  logic [SET_W-1:0]   settle_cnt_q;
  logic [N_MSHR-1:0]  active_q;
  logic [N_MSHR-1:0]  expired_q;
  logic [TIMER_W-1:0] timer_q [N_MSHR];
  logic [ID_W-1:0]    rr_q;
  logic [ID_W-1:0]    hi_sel, lo_sel;
  logic               hi_found;
  logic               handshake;
  logic               run;

  // Two-flop synchronizer for the asynchronous calibration-complete level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      calib_s1 <= 1'b0;
      calib_s2 <= 1'b0;
    end else begin
      calib_s1 <= calib_done;
      calib_s2 <= calib_s1;
    end
  end

  // Phase register; RUN is only left through reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= WAIT_CALIB;
    else       state_q <= state_d;
  end

  // Phase sequencing and phase-derived outputs.
  always_comb begin
    state_d        = state_q;
    phase          = state_q;
    timers_enabled = 1'b0;
    case (state_q)
      WAIT_CALIB: if (calib_s2) state_d = SETTLE;
      SETTLE:     if (settle_cnt_q == SETTLE_LAST) state_d = RUN;
      RUN:        timers_enabled = 1'b1;
      default:    state_d = WAIT_CALIB;
    endcase
  end

  // Settle counter: parked at 0 while waiting so it enters SETTLE at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      settle_cnt_q <= '0;
    end else if (state_q == WAIT_CALIB) begin
      settle_cnt_q <= '0;
    end else if (state_q == SETTLE) begin
      settle_cnt_q <= settle_cnt_q + SET_W'(1);
    end
  end

  assign run          = (state_q == RUN);
  assign expired_vec  = expired_q;
  assign expire_valid = |expired_q;
  assign handshake    = expire_valid & expire_ready;

  // Round-robin pick: lowest expired index at or above the pointer, else lowest overall (wrap).
  always_comb begin
    hi_sel   = '0;
    lo_sel   = '0;
    hi_found = 1'b0;
    for (int i = N_MSHR - 1; i >= 0; i--) begin
      if (expired_q[i]) begin
        lo_sel = ID_W'(i);
        if (i >= int'(rr_q)) begin
          hi_sel   = ID_W'(i);
          hi_found = 1'b1;
        end
      end
    end
    expire_id = '0;
    if (expire_valid) expire_id = hi_found ? hi_sel : lo_sel;
  end

  // Pointer advances past the accepted id only on a handshake, keeping expire_id stable otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q <= '0;
    end else if (handshake) begin
      rr_q <= (expire_id == ID_LAST) ? '0 : expire_id + ID_W'(1);
    end
  end

  // Per-MSHR timers: alloc beats free beats service beats counting; an expired timer holds at TIMEOUT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_q  <= '0;
      expired_q <= '0;
      for (int i = 0; i < N_MSHR; i++) timer_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_MSHR; i++) begin
        if (mshr_alloc[i]) begin
          active_q[i]  <= 1'b1;
          expired_q[i] <= 1'b0;
          timer_q[i]   <= '0;
        end else if (mshr_free[i]) begin
          active_q[i]  <= 1'b0;
          expired_q[i] <= 1'b0;
          timer_q[i]   <= '0;
        end else if (handshake && (expire_id == ID_W'(i))) begin
          expired_q[i] <= 1'b0;
          timer_q[i]   <= '0;
        end else if (run && active_q[i] && !expired_q[i]) begin
          if (timer_q[i] == TIMER_LAST) begin
            timer_q[i]   <= TIMER_EXP;
            expired_q[i] <= 1'b1;
          end else begin
            timer_q[i] <= timer_q[i] + TIMER_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mshr_timer_sched.sv
// Directed bench for mshr_timer_sched with a queue of expected expiry ids.
// Bench config: N_MSHR=5, TIMEOUT=8, SETTLE_CYCLES=16.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_mshr_timer_sched;

  localparam int N  = 5;
  localparam int TO = 8;
  localparam int ST = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         calib_done;
  logic [N-1:0] mshr_alloc;
  logic [N-1:0] mshr_free;
  logic         expire_valid;
  logic [2:0]   expire_id;
  logic         expire_ready;
  logic         timers_enabled;
  logic [1:0]   phase;
  logic [N-1:0] expired_vec;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int exp_q[$];
  int pop_cyc[$];
  int t0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mshr_timer_sched #(
    .N_MSHR(N), .TIMER_W(16), .TIMEOUT(TO), .SETTLE_CYCLES(ST)
  ) dut (
    .clock(clock), .reset(reset), .calib_done(calib_done),
    .mshr_alloc(mshr_alloc), .mshr_free(mshr_free),
    .expire_valid(expire_valid), .expire_id(expire_id), .expire_ready(expire_ready),
    .timers_enabled(timers_enabled), .phase(phase), .expired_vec(expired_vec)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // Advance until every queued id has been presented (or the budget runs out).
  task automatic drain(input int budget);
    int n;
    n = 0;
    pop_cyc.delete();
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
      if (expire_valid) begin
        int e;
        e = exp_q.pop_front();
        check("expire_id", 32'(expire_id), e);
        pop_cyc.push_back(cyc);
      end
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; calib_done = 1'b0; mshr_alloc = '0; mshr_free = '0; expire_ready = 1'b0;
    #1;
    check("rst_phase", 32'(phase), 0);
    check("rst_ten", 32'(timers_enabled), 0);
    check("rst_valid", 32'(expire_valid), 0);
    check("rst_id", 32'(expire_id), 0);
    check("rst_vec", 32'(expired_vec), 0);
    ticks(2);
    reset = 1'b0;

    // 1: no calibration -> timers frozen, nothing expires
    mshr_alloc = 5'b00001;
    tick();
    mshr_alloc = '0;
    for (int k = 0; k < 100; k++) begin
      tick();
      check("wait_hold", 32'({phase, expire_valid, dut.timer_q[0]}), 0);
    end

    // 2: calibration -> SETTLE after 3 edges, RUN after 19; MSHR0 then expires 8 later
    calib_done = 1'b1;
    ticks(2);
    check("sync_delay", 32'(phase), 0);
    tick();
    check("settle_entry", 32'(phase), 1);
    ticks(15);
    check("settle_last", 32'({phase, timers_enabled}), 32'({2'd1, 1'b0}));
    tick();
    check("run_entry", 32'({phase, timers_enabled}), 32'({2'd2, 1'b1}));
    t0 = cyc;
    exp_q.push_back(0);
    drain(20);
    check("mshr0_latency", pop_cyc[0] - t0, TO);
    mshr_free = 5'b00001;
    tick();
    mshr_free = '0;
    check("free0_vec", 32'(expired_vec), 0);

    // 3: single expiry held under backpressure, then restarted by the handshake
    mshr_alloc = 5'b00100;
    tick();
    mshr_alloc = '0;
    t0 = cyc;
    exp_q.push_back(2);
    drain(20);
    check("mshr2_latency", pop_cyc[0] - t0, TO);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("hold_stable", 32'({expire_valid, expire_id}), 32'h0A);
    end
    expire_ready = 1'b1;
    tick();
    expire_ready = 1'b0;
    check("accept_drop", 32'(expire_valid), 0);
    t0 = cyc;
    exp_q.push_back(2);
    drain(20);
    check("rearm_latency", pop_cyc[0] - t0, TO);
    // pointer is now 3; move it to 0 by serving MSHR4 in the same cycle it is freed
    mshr_free = 5'b00100; mshr_alloc = 5'b10000;
    tick();
    mshr_free = '0; mshr_alloc = '0;
    check("free2_vec", 32'(expired_vec), 0);
    t0 = cyc;
    exp_q.push_back(4);
    drain(20);
    check("mshr4_latency", pop_cyc[0] - t0, TO);
    expire_ready = 1'b1; mshr_free = 5'b10000;
    tick();
    expire_ready = 1'b0; mshr_free = '0;
    check("hs_free_vec", 32'({expire_valid, expired_vec}), 0);

    // 4: four simultaneous expiries served round-robin, two rounds from pointer 0
    mshr_alloc = 5'b11011; expire_ready = 1'b1;
    tick();
    mshr_alloc = '0;
    t0 = cyc;
    exp_q = '{0, 1, 3, 4, 0, 1, 3, 4};
    drain(40);
    check("rr_first_latency", pop_cyc[0] - t0, TO);
    check("rr_round1_span", pop_cyc[3] - pop_cyc[0], 3);
    check("rr_round2_start", pop_cyc[4] - pop_cyc[0], TO + 1);
    check("rr_round2_span", pop_cyc[7] - pop_cyc[4], 3);
    tick();
    expire_ready = 1'b0;

    // 5: withdrawal of presented id by free; same-cycle alloc+free restarts MSHR4
    mshr_free = 5'b00001;
    tick();
    mshr_free = '0;
    check("free0b_vec", 32'(expired_vec), 0);
    ticks(5);
    check("present1_vec", 32'(expired_vec), 32'(5'b00010));
    check("present1_id", 32'(expire_id), 1);
    mshr_free = 5'b00010;
    tick();
    mshr_free = '0;
    check("withdraw_vec", 32'(expired_vec), 32'(5'b01000));
    check("withdraw_id", 32'({expire_valid, expire_id}), 32'h0B);
    mshr_alloc = 5'b10000; mshr_free = 5'b10000;
    tick();
    mshr_alloc = '0; mshr_free = '0;
    check("allocfree_vec", 32'(expired_vec), 32'(5'b01000));
    ticks(7);
    check("restart_pre", 32'(expired_vec), 32'(5'b01000));
    tick();
    check("restart_exp", 32'(expired_vec), 32'(5'b11000));
    check("restart_id", 32'(expire_id), 3);

    // 6: asynchronous reset mid-RUN with three expired flags, then full re-sequence
    mshr_alloc = 5'b00001;
    tick();
    mshr_alloc = '0;
    ticks(TO);
    check("pre_reset_vec", 32'(expired_vec), 32'(5'b11001));
    check("pre_reset_id", 32'(expire_id), 0);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(expire_valid), 0);
    check("arst_id", 32'(expire_id), 0);
    check("arst_vec", 32'(expired_vec), 0);
    check("arst_phase", 32'({phase, timers_enabled}), 0);
    ticks(2);
    reset = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      int ph;
      tick();
      ph = (k < 3) ? 0 : ((k < 19) ? 1 : 2);
      check("reseq_phase", 32'(phase), ph);
      check("reseq_valid", 32'(expire_valid), 0);
    end
    check("reseq_ten", 32'(timers_enabled), 1);
    ticks(10);
    check("reseq_quiet", 32'(expired_vec), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
